// File: rtl/bm_pkg.sv
// bm_pkg: shared definitions for the bomberman VGA datapath.
//   - coordinate width and screen size
//   - facing/direction codes (as seen on the facing output)
//   - movement FSM state encoding
//   - bit positions of the {left,right,up,down} collision/button vectors
//   - clamp_coord(): saturate an 11-bit signed coordinate into [lo, hi]
package bm_pkg;

    localparam int COORD_W  = 10;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef logic signed [COORD_W:0] scoord_t;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_RIGHT = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MV_L = 3'd1,
        ST_MV_R = 3'd2,
        ST_MV_U = 3'd3,
        ST_MV_D = 3'd4
    } state_e;

    // Bit positions inside blocked[3:0] and the packed button vector.
    localparam int BLK_L = 3;
    localparam int BLK_R = 2;
    localparam int BLK_U = 1;
    localparam int BLK_D = 0;

    localparam logic [3:0] MASK_L = 4'b0001 << BLK_L;
    localparam logic [3:0] MASK_R = 4'b0001 << BLK_R;
    localparam logic [3:0] MASK_U = 4'b0001 << BLK_U;
    localparam logic [3:0] MASK_D = 4'b0001 << BLK_D;

    function automatic logic [COORD_W-1:0] clamp_coord(input scoord_t v,
                                                      input scoord_t lo,
                                                      input scoord_t hi);
        logic [COORD_W-1:0] r;
        if (v < lo) begin
            r = lo[COORD_W-1:0];
        end else if (v > hi) begin
            r = hi[COORD_W-1:0];
        end else begin
            r = v[COORD_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/player_motion_ctrl_if.sv
// player_motion_ctrl_if: signal bundle between one player's motion controller
// and its surroundings (button conditioner, collision compare, pixel mux).
// Suffixes are relative to the controller: _i into it, _o out of it.
//   move_tick_i          movement strobe
//   btn_{l,r,u,d}_i      held-level direction requests
//   blocked_i[3:0]       collision flags {left,right,up,down}
//   game_over_i          freeze request
//   v_x_i, v_y_i         current VGA pixel coordinate
//   pos_x_o, pos_y_o     sprite top-left corner
//   facing_o             0=down 1=up 2=right 3=left
//   moving_o             high while in a move state
//   anim_frame_o         walk frame 0..3
//   sprite_on_o          pixel inside sprite box
//   rom_col_o, rom_row_o sprite ROM address (valid when sprite_on_o)
// Modports: master = environment side, slave = controller side.
interface player_motion_ctrl_if
    import bm_pkg::*;
#(
    parameter int SPR_W = 16,
    parameter int SPR_H = 16
);
    localparam int COL_W = $clog2(SPR_W);
    localparam int ROW_W = $clog2(SPR_H);

    logic               move_tick_i;
    logic               btn_l_i;
    logic               btn_r_i;
    logic               btn_u_i;
    logic               btn_d_i;
    logic [3:0]         blocked_i;
    logic               game_over_i;
    logic [COORD_W-1:0] v_x_i;
    logic [COORD_W-1:0] v_y_i;

    logic [COORD_W-1:0] pos_x_o;
    logic [COORD_W-1:0] pos_y_o;
    logic [1:0]         facing_o;
    logic               moving_o;
    logic [1:0]         anim_frame_o;
    logic               sprite_on_o;
    logic [COL_W-1:0]   rom_col_o;
    logic [ROW_W-1:0]   rom_row_o;

    modport master (
        output move_tick_i, btn_l_i, btn_r_i, btn_u_i, btn_d_i,
               blocked_i, game_over_i, v_x_i, v_y_i,
        input  pos_x_o, pos_y_o, facing_o, moving_o, anim_frame_o,
               sprite_on_o, rom_col_o, rom_row_o
    );

    modport slave (
        input  move_tick_i, btn_l_i, btn_r_i, btn_u_i, btn_d_i,
               blocked_i, game_over_i, v_x_i, v_y_i,
        output pos_x_o, pos_y_o, facing_o, moving_o, anim_frame_o,
               sprite_on_o, rom_col_o, rom_row_o
    );

endinterface

// File: rtl/sprite_hit.sv
// sprite_hit: combinational box test of a pixel against a sprite placed at
// (pos_x_i, pos_y_i), plus the sprite-local column/row for ROM addressing.
//   pos_x_i, pos_y_i  sprite top-left corner
//   v_x_i, v_y_i      pixel coordinate
//   hit_o             pixel inside [pos, pos+SPR-1] on both axes
//   col_o, row_o      v - pos truncated; meaningful only when hit_o
module sprite_hit
    import bm_pkg::*;
#(
    parameter int SPR_W = 16,
    parameter int SPR_H = 16,
    parameter int COL_W = $clog2(SPR_W),
    parameter int ROW_W = $clog2(SPR_H)
) (
    input  logic [COORD_W-1:0] pos_x_i,
    input  logic [COORD_W-1:0] pos_y_i,
    input  logic [COORD_W-1:0] v_x_i,
    input  logic [COORD_W-1:0] v_y_i,
    output logic               hit_o,
    output logic [COL_W-1:0]   col_o,
    output logic [ROW_W-1:0]   row_o
);
    // One extra bit so a pixel left of/above the sprite wraps to a large
    // value and fails the "< size" test instead of aliasing into the box.
    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;

    assign dx = {1'b0, v_x_i} - {1'b0, pos_x_i};
    assign dy = {1'b0, v_y_i} - {1'b0, pos_y_i};

    assign hit_o = (v_x_i >= pos_x_i) && (dx < (COORD_W+1)'(SPR_W)) &&
                   (v_y_i >= pos_y_i) && (dy < (COORD_W+1)'(SPR_H));
    assign col_o = dx[COL_W-1:0];
    assign row_o = dy[ROW_W-1:0];

endmodule

// File: rtl/player_motion_ctrl.sv
// player_motion_ctrl: per-player sprite motion controller.
// Turns held direction buttons into a clamped, collision-gated sprite position
// that advances only on move_tick, tracks facing and a walk-animation frame,
// and provides the pixel hit test / ROM address for the colour mux.
//   clk          system clock
//   reset        asynchronous, active-high
//   bus          player_motion_ctrl_if.slave (all data/control signals)
//   state_dbg_o  current FSM state
module player_motion_ctrl
    import bm_pkg::*;
#(
    parameter int SPR_W    = 16,
    parameter int SPR_H    = 16,
    parameter int MIN_X    = 0,
    parameter int MAX_X    = SCREEN_W,
    parameter int MIN_Y    = 16,
    parameter int MAX_Y    = SCREEN_H,
    parameter int INIT_X   = 0,
    parameter int INIT_Y   = 16,
    parameter int STEP     = 1,
    parameter int ANIM_DIV = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    player_motion_ctrl_if.slave  bus,
    output state_e               state_dbg_o
);
    localparam int                CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ANIM_DIV - 1);
    localparam scoord_t           STEP_S   = scoord_t'(STEP);
    localparam scoord_t           LO_X     = scoord_t'(MIN_X);
    localparam scoord_t           HI_X     = scoord_t'(MAX_X - SPR_W);
    localparam scoord_t           LO_Y     = scoord_t'(MIN_Y);
    localparam scoord_t           HI_Y     = scoord_t'(MAX_Y - SPR_H);

    state_e             state_q;
    dir_e               facing_q;
    logic [COORD_W-1:0] pos_x_q;
    logic [COORD_W-1:0] pos_y_q;
    logic               moving_q;
    logic [1:0]         anim_q;
    logic [CNT_W-1:0]   step_cnt_q;

    logic [3:0]         btn_vec;
    logic [3:0]         own_mask;
    logic               req_valid_d;
    state_e             req_state_d;
    dir_e               req_dir_d;
    logic [COORD_W-1:0] pos_x_d;
    logic [COORD_W-1:0] pos_y_d;
    logic               step_ok_d;
    logic               leave_d;

    // Packed in the same {left,right,up,down} order as blocked_i.
    assign btn_vec = {bus.btn_l_i, bus.btn_r_i, bus.btn_u_i, bus.btn_d_i};

    // Decode a single-button request from IDLE; zero or several buttons
    // leave req_valid_d low.
    always_comb begin
        req_valid_d = 1'b1;
        req_state_d = ST_IDLE;
        req_dir_d   = DIR_DOWN;
        case (btn_vec)
            MASK_L:  begin req_state_d = ST_MV_L; req_dir_d = DIR_LEFT;  end
            MASK_R:  begin req_state_d = ST_MV_R; req_dir_d = DIR_RIGHT; end
            MASK_U:  begin req_state_d = ST_MV_U; req_dir_d = DIR_UP;    end
            MASK_D:  begin req_state_d = ST_MV_D; req_dir_d = DIR_DOWN;  end
            default: req_valid_d = 1'b0;
        endcase
    end

    // Candidate position for the current move direction, saturated to the
    // play area. own_mask selects this direction's button and blocked bit.
    always_comb begin
        own_mask = 4'b0000;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        case (state_q)
            ST_MV_L: begin
                own_mask = MASK_L;
                pos_x_d  = clamp_coord(scoord_t'(pos_x_q) - STEP_S, LO_X, HI_X);
            end
            ST_MV_R: begin
                own_mask = MASK_R;
                pos_x_d  = clamp_coord(scoord_t'(pos_x_q) + STEP_S, LO_X, HI_X);
            end
            ST_MV_U: begin
                own_mask = MASK_U;
                pos_y_d  = clamp_coord(scoord_t'(pos_y_q) - STEP_S, LO_Y, HI_Y);
            end
            ST_MV_D: begin
                own_mask = MASK_D;
                pos_y_d  = clamp_coord(scoord_t'(pos_y_q) + STEP_S, LO_Y, HI_Y);
            end
            default: ;
        endcase

        // A step pinned at the bound (no position change) is not accepted,
        // so it does not feed the animation counter either.
        step_ok_d = (|(btn_vec & own_mask)) && bus.move_tick_i &&
                    !(|(bus.blocked_i & own_mask)) && !bus.game_over_i &&
                    ((pos_x_d != pos_x_q) || (pos_y_d != pos_y_q));

        // Stay in MV_x only while exactly its own button is held.
        leave_d = (btn_vec != own_mask) || bus.game_over_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            facing_q   <= DIR_DOWN;
            pos_x_q    <= COORD_W'(INIT_X);
            pos_y_q    <= COORD_W'(INIT_Y);
            moving_q   <= 1'b0;
            anim_q     <= 2'd0;
            step_cnt_q <= '0;
        end else begin
            if (step_ok_d) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
                if (step_cnt_q == CNT_LAST) begin
                    step_cnt_q <= '0;
                    anim_q     <= anim_q + 2'd1;
                end else begin
                    step_cnt_q <= step_cnt_q + CNT_W'(1);
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (req_valid_d && !bus.game_over_i) begin
                        state_q  <= req_state_d;
                        facing_q <= req_dir_d;
                        moving_q <= 1'b1;
                    end
                end
                default: begin
                    // Written after the step update so the clear on IDLE
                    // entry wins over a same-edge step. Under game_over the
                    // animation frame is frozen rather than cleared.
                    if (leave_d) begin
                        state_q    <= ST_IDLE;
                        moving_q   <= 1'b0;
                        step_cnt_q <= '0;
                        if (!bus.game_over_i) begin
                            anim_q <= 2'd0;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.pos_x_o      = pos_x_q;
    assign bus.pos_y_o      = pos_y_q;
    assign bus.facing_o     = facing_q;
    assign bus.moving_o     = moving_q;
    assign bus.anim_frame_o = anim_q;
    assign state_dbg_o      = state_q;

    sprite_hit #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_sprite_hit (
        .pos_x_i (pos_x_q),
        .pos_y_i (pos_y_q),
        .v_x_i   (bus.v_x_i),
        .v_y_i   (bus.v_y_i),
        .hit_o   (bus.sprite_on_o),
        .col_o   (bus.rom_col_o),
        .row_o   (bus.rom_row_o)
    );

endmodule

// File: tb/tb_player_motion_ctrl.sv
module tb_player_motion_ctrl;
    import bm_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    player_motion_ctrl_if ba ();
    player_motion_ctrl_if bb ();
    state_e st_a;
    state_e st_b;

    // Default instance: INIT=(0,16), STEP=1, ANIM_DIV=8.
    player_motion_ctrl u_a (
        .clk         (clk),
        .reset       (reset),
        .bus         (ba.slave),
        .state_dbg_o (st_a)
    );

    // Clamp instance: starts near the right edge, big step, one step per frame.
    player_motion_ctrl #(
        .INIT_X   (622),
        .STEP     (4),
        .ANIM_DIV (1)
    ) u_b (
        .clk         (clk),
        .reset       (reset),
        .bus         (bb.slave),
        .state_dbg_o (st_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- driver tasks ----------------
    task automatic init_inputs();
        ba.move_tick_i = 1'b0; ba.btn_l_i = 1'b0; ba.btn_r_i = 1'b0;
        ba.btn_u_i = 1'b0; ba.btn_d_i = 1'b0; ba.blocked_i = 4'b0000;
        ba.game_over_i = 1'b0; ba.v_x_i = '0; ba.v_y_i = '0;
        bb.move_tick_i = 1'b0; bb.btn_l_i = 1'b0; bb.btn_r_i = 1'b0;
        bb.btn_u_i = 1'b0; bb.btn_d_i = 1'b0; bb.blocked_i = 4'b0000;
        bb.game_over_i = 1'b0; bb.v_x_i = '0; bb.v_y_i = '0;
    endtask

    // Called at a negedge; each tick is one high cycle then one low cycle.
    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ba.move_tick_i = 1'b1;
            bb.move_tick_i = 1'b1;
            @(negedge clk);
            ba.move_tick_i = 1'b0;
            bb.move_tick_i = 1'b0;
            @(negedge clk);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        init_inputs();
        repeat (2) @(negedge clk);
        n_cmp++; if (ba.pos_x_o !== 10'd0) begin n_fail++; $display("FAIL reset_pos_x: got %0d want 0", ba.pos_x_o); end
        n_cmp++; if (ba.pos_y_o !== 10'd16) begin n_fail++; $display("FAIL reset_pos_y: got %0d want 16", ba.pos_y_o); end
        n_cmp++; if (ba.facing_o !== 2'd0) begin n_fail++; $display("FAIL reset_facing: got %0d want 0", ba.facing_o); end
        n_cmp++; if (ba.anim_frame_o !== 2'd0) begin n_fail++; $display("FAIL reset_anim: got %0d want 0", ba.anim_frame_o); end
        n_cmp++; if (ba.moving_o !== 1'b0) begin n_fail++; $display("FAIL reset_moving: got %0b want 0", ba.moving_o); end
        n_cmp++; if (bb.pos_x_o !== 10'd622) begin n_fail++; $display("FAIL reset_b_pos_x: got %0d want 622", bb.pos_x_o); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", st_a, ST_IDLE); end
    endtask

    task automatic test_move_right();
        // Tick in the entry cycle must be ignored.
        ba.btn_r_i = 1'b1;
        ba.move_tick_i = 1'b1;
        @(negedge clk);
        ba.move_tick_i = 1'b0;
        n_cmp++; if (ba.moving_o !== 1'b1) begin n_fail++; $display("FAIL right_moving: got %0b want 1", ba.moving_o); end
        n_cmp++; if (ba.facing_o !== 2'd2) begin n_fail++; $display("FAIL right_facing: got %0d want 2", ba.facing_o); end
        n_cmp++; if (ba.pos_x_o !== 10'd0) begin n_fail++; $display("FAIL right_entry_tick: got %0d want 0", ba.pos_x_o); end
        do_ticks(5);
        n_cmp++; if (ba.pos_x_o !== 10'd5) begin n_fail++; $display("FAIL right_pos_x: got %0d want 5", ba.pos_x_o); end
        // Release together with a tick: no step.
        ba.btn_r_i = 1'b0;
        ba.move_tick_i = 1'b1;
        @(negedge clk);
        ba.move_tick_i = 1'b0;
        n_cmp++; if (ba.moving_o !== 1'b0) begin n_fail++; $display("FAIL right_release_moving: got %0b want 0", ba.moving_o); end
        n_cmp++; if (ba.pos_x_o !== 10'd5) begin n_fail++; $display("FAIL right_release_tick: got %0d want 5", ba.pos_x_o); end
        n_cmp++; if (ba.anim_frame_o !== 2'd0) begin n_fail++; $display("FAIL right_release_anim: got %0d want 0", ba.anim_frame_o); end
        n_cmp++; if (ba.facing_o !== 2'd2) begin n_fail++; $display("FAIL right_facing_hold: got %0d want 2", ba.facing_o); end
    endtask

    task automatic test_collision_game_over();
        // Move down 4 first so an unblocked up step would be visible.
        ba.btn_d_i = 1'b1;
        @(negedge clk);
        do_ticks(4);
        n_cmp++; if (ba.pos_y_o !== 10'd20) begin n_fail++; $display("FAIL down_pos_y: got %0d want 20", ba.pos_y_o); end
        ba.btn_d_i = 1'b0;
        @(negedge clk);
        ba.btn_u_i = 1'b1;
        ba.blocked_i = 4'b0010;
        @(negedge clk);
        n_cmp++; if (ba.facing_o !== 2'd1) begin n_fail++; $display("FAIL up_facing: got %0d want 1", ba.facing_o); end
        do_ticks(3);
        n_cmp++; if (ba.pos_y_o !== 10'd20) begin n_fail++; $display("FAIL blocked_pos_y: got %0d want 20", ba.pos_y_o); end
        ba.blocked_i = 4'b0000;
        ba.game_over_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL gameover_state: got %0d want %0d", st_a, ST_IDLE); end
        do_ticks(3);
        n_cmp++; if (ba.pos_y_o !== 10'd20) begin n_fail++; $display("FAIL gameover_pos_y: got %0d want 20", ba.pos_y_o); end
        n_cmp++; if (ba.moving_o !== 1'b0) begin n_fail++; $display("FAIL gameover_moving: got %0b want 0", ba.moving_o); end
        n_cmp++; if (ba.facing_o !== 2'd1) begin n_fail++; $display("FAIL gameover_facing: got %0d want 1", ba.facing_o); end
        ba.game_over_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (st_a !== ST_MV_U) begin n_fail++; $display("FAIL resume_state: got %0d want %0d", st_a, ST_MV_U); end
        do_ticks(1);
        n_cmp++; if (ba.pos_y_o !== 10'd19) begin n_fail++; $display("FAIL resume_pos_y: got %0d want 19", ba.pos_y_o); end
        ba.btn_u_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multi_anim();
        ba.btn_r_i = 1'b1;
        @(negedge clk);
        do_ticks(20);
        n_cmp++; if (ba.pos_x_o !== 10'd25) begin n_fail++; $display("FAIL anim_r_pos_x: got %0d want 25", ba.pos_x_o); end
        n_cmp++; if (ba.anim_frame_o !== 2'd2) begin n_fail++; $display("FAIL anim_r_frame: got %0d want 2", ba.anim_frame_o); end
        ba.btn_r_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (ba.anim_frame_o !== 2'd0) begin n_fail++; $display("FAIL anim_idle_clear: got %0d want 0", ba.anim_frame_o); end
        // Two buttons: stay IDLE.
        ba.btn_l_i = 1'b1;
        ba.btn_d_i = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (st_a !== ST_IDLE) begin n_fail++; $display("FAIL multi_state: got %0d want %0d", st_a, ST_IDLE); end
        do_ticks(1);
        n_cmp++; if (ba.pos_x_o !== 10'd25 || ba.pos_y_o !== 10'd19) begin n_fail++; $display("FAIL multi_pos: got (%0d,%0d) want (25,19)", ba.pos_x_o, ba.pos_y_o); end
        ba.btn_d_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (st_a !== ST_MV_L) begin n_fail++; $display("FAIL left_state: got %0d want %0d", st_a, ST_MV_L); end
        n_cmp++; if (ba.facing_o !== 2'd3) begin n_fail++; $display("FAIL left_facing: got %0d want 3", ba.facing_o); end
        do_ticks(7);
        n_cmp++; if (ba.anim_frame_o !== 2'd0) begin n_fail++; $display("FAIL left_anim7: got %0d want 0", ba.anim_frame_o); end
        do_ticks(1);
        n_cmp++; if (ba.anim_frame_o !== 2'd1) begin n_fail++; $display("FAIL left_anim8: got %0d want 1", ba.anim_frame_o); end
        do_ticks(8);
        n_cmp++; if (ba.anim_frame_o !== 2'd2) begin n_fail++; $display("FAIL left_anim16: got %0d want 2", ba.anim_frame_o); end
        n_cmp++; if (ba.pos_x_o !== 10'd9) begin n_fail++; $display("FAIL left_pos_x: got %0d want 9", ba.pos_x_o); end
        ba.btn_l_i = 1'b0;
        @(negedge clk);
        // Left boundary: 12 ticks from x=9 pin at MIN_X=0.
        ba.btn_l_i = 1'b1;
        @(negedge clk);
        do_ticks(12);
        n_cmp++; if (ba.pos_x_o !== 10'd0) begin n_fail++; $display("FAIL left_clamp: got %0d want 0", ba.pos_x_o); end
        ba.btn_l_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clamp();
        bb.btn_r_i = 1'b1;
        @(negedge clk);
        n_cmp++; if (st_b !== ST_MV_R) begin n_fail++; $display("FAIL clamp_state: got %0d want %0d", st_b, ST_MV_R); end
        do_ticks(1);
        n_cmp++; if (bb.pos_x_o !== 10'd624) begin n_fail++; $display("FAIL clamp_first: got %0d want 624", bb.pos_x_o); end
        n_cmp++; if (bb.anim_frame_o !== 2'd1) begin n_fail++; $display("FAIL clamp_first_anim: got %0d want 1", bb.anim_frame_o); end
        do_ticks(3);
        n_cmp++; if (bb.pos_x_o !== 10'd624) begin n_fail++; $display("FAIL clamp_hold: got %0d want 624", bb.pos_x_o); end
        n_cmp++; if (bb.anim_frame_o !== 2'd1) begin n_fail++; $display("FAIL clamp_anim_hold: got %0d want 1", bb.anim_frame_o); end
        bb.btn_r_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bb.moving_o !== 1'b0) begin n_fail++; $display("FAIL clamp_release: got %0b want 0", bb.moving_o); end
    endtask

    task automatic test_hit();
        // Walk instance A from (0,19) to (100,50).
        ba.btn_r_i = 1'b1;
        @(negedge clk);
        do_ticks(100);
        ba.btn_r_i = 1'b0;
        @(negedge clk);
        ba.btn_d_i = 1'b1;
        @(negedge clk);
        do_ticks(31);
        ba.btn_d_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (ba.pos_x_o !== 10'd100 || ba.pos_y_o !== 10'd50) begin n_fail++; $display("FAIL hit_setup: got (%0d,%0d) want (100,50)", ba.pos_x_o, ba.pos_y_o); end

        ba.v_x_i = 10'd115; ba.v_y_i = 10'd65; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b1) begin n_fail++; $display("FAIL hit_corner_br: got %0b want 1", ba.sprite_on_o); end
        n_cmp++; if (ba.rom_col_o !== 4'd15 || ba.rom_row_o !== 4'd15) begin n_fail++; $display("FAIL hit_corner_addr: got (%0d,%0d) want (15,15)", ba.rom_col_o, ba.rom_row_o); end
        ba.v_x_i = 10'd116; ba.v_y_i = 10'd65; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b0) begin n_fail++; $display("FAIL hit_right_out: got %0b want 0", ba.sprite_on_o); end
        ba.v_x_i = 10'd115; ba.v_y_i = 10'd66; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b0) begin n_fail++; $display("FAIL hit_below_out: got %0b want 0", ba.sprite_on_o); end
        ba.v_x_i = 10'd100; ba.v_y_i = 10'd50; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b1 || ba.rom_col_o !== 4'd0 || ba.rom_row_o !== 4'd0) begin n_fail++; $display("FAIL hit_corner_tl: got on=%0b (%0d,%0d) want on=1 (0,0)", ba.sprite_on_o, ba.rom_col_o, ba.rom_row_o); end
        ba.v_x_i = 10'd99; ba.v_y_i = 10'd50; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b0) begin n_fail++; $display("FAIL hit_left_out: got %0b want 0", ba.sprite_on_o); end
        ba.v_x_i = 10'd100; ba.v_y_i = 10'd49; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b0) begin n_fail++; $display("FAIL hit_above_out: got %0b want 0", ba.sprite_on_o); end
        ba.v_x_i = 10'd107; ba.v_y_i = 10'd60; #1;
        n_cmp++; if (ba.sprite_on_o !== 1'b1 || ba.rom_col_o !== 4'd7 || ba.rom_row_o !== 4'd10) begin n_fail++; $display("FAIL hit_mid: got on=%0b (%0d,%0d) want on=1 (7,10)", ba.sprite_on_o, ba.rom_col_o, ba.rom_row_o); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        ba.btn_r_i = 1'b1;
        @(negedge clk);
        do_ticks(2);
        n_cmp++; if (ba.pos_x_o !== 10'd102) begin n_fail++; $display("FAIL pre_reset_pos_x: got %0d want 102", ba.pos_x_o); end
        // Assert reset away from any clock edge; outputs must change at once.
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ba.pos_x_o !== 10'd0 || ba.pos_y_o !== 10'd16) begin n_fail++; $display("FAIL async_reset_pos: got (%0d,%0d) want (0,16)", ba.pos_x_o, ba.pos_y_o); end
        n_cmp++; if (ba.moving_o !== 1'b0 || st_a !== ST_IDLE) begin n_fail++; $display("FAIL async_reset_state: got moving=%0b state=%0d want 0/%0d", ba.moving_o, st_a, ST_IDLE); end
        n_cmp++; if (ba.facing_o !== 2'd0) begin n_fail++; $display("FAIL async_reset_facing: got %0d want 0", ba.facing_o); end
        n_cmp++; if (bb.pos_x_o !== 10'd622) begin n_fail++; $display("FAIL async_reset_b_pos_x: got %0d want 622", bb.pos_x_o); end
        ba.btn_r_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (st_a !== ST_IDLE || ba.pos_x_o !== 10'd0) begin n_fail++; $display("FAIL post_reset: got state=%0d x=%0d want %0d/0", st_a, ba.pos_x_o, ST_IDLE); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_move_right();
        test_collision_game_over();
        test_multi_anim();
        test_clamp();
        test_hit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
